// File: rtl/instr_encoder_pkg.sv
// Shared opcode constants, FSM state and instruction-kind types for the instruction encoder.
// Also holds the immediate legality check used when INSTR_ENCODER_RANGE_CHECK_EN is defined.
package instr_pkg;

   localparam logic [6:0] OP_IMM_ALU = 7'b0010011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef enum logic {
      KIND_ITYPE = 1'b0,
      KIND_BTYPE = 1'b1
   } kind_t;

   // I-type fits 12 signed bits when bits 12 and 11 agree; branch offsets must be even
   function automatic logic imm_ok(input kind_t kind, input logic [12:0] imm);
      logic ok;
      case (kind)
         KIND_ITYPE: ok = (imm[12] == imm[11]);
         KIND_BTYPE: ok = (imm[0] == 1'b0);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Beat-input and instruction-memory write bus of the instruction encoder.
interface instr_encoder_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_kind;
   logic [2:0]            in_funct3;
   logic [4:0]            in_rd;
   logic [4:0]            in_rs1;
   logic [4:0]            in_rs2;
   logic [12:0]           in_imm;
   logic                  flush;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  full;
   logic                  err;

   modport master (
      output in_valid, in_kind, in_funct3, in_rd, in_rs1, in_rs2, in_imm, flush,
      input  in_ready, mem_we, mem_addr, mem_wdata, full, err
   );

   modport slave (
      input  in_valid, in_kind, in_funct3, in_rd, in_rs1, in_rs2, in_imm, flush,
      output in_ready, mem_we, mem_addr, mem_wdata, full, err
   );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational RV32 field packer: I-type ALU-immediate and B-type branch formats.
module instr_pack
   import instr_pkg::*;
(
   input  kind_t       i_kind,
   input  logic [2:0]  i_funct3,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [12:0] i_imm,
   output logic [31:0] o_word
);

   // Branch immediates are scrambled so the sign always sits in bit 31
   always_comb begin
      o_word = 32'h0000_0000;
      case (i_kind)
         KIND_ITYPE: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IMM_ALU};
         KIND_BTYPE: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], OP_BRANCH};
         default:    o_word = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field beats into words and writes them to sequential memory addresses.
// Optional INSTR_ENCODER_RANGE_CHECK_EN rejects out-of-range immediates with an err pulse.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic            clk,
   input  logic            rst,
   instr_encoder_if.slave  bus
);

   localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [31:0]           r_word;
   logic [31:0]           w_word;
   logic                  r_we;
   logic                  r_full;
   logic                  w_hs;
   logic                  w_ok;
   logic                  w_accept;
   logic                  w_last;

   instr_pack u_pack (
      .i_kind   (kind_t'(bus.in_kind)),
      .i_funct3 (bus.in_funct3),
      .i_rd     (bus.in_rd),
      .i_rs1    (bus.in_rs1),
      .i_rs2    (bus.in_rs2),
      .i_imm    (bus.in_imm),
      .o_word   (w_word)
   );

   assign bus.in_ready = (r_state == ST_IDLE) && !bus.flush && !rst;
   assign w_hs         = bus.in_valid && bus.in_ready;
   assign w_last       = (r_cnt == LAST_ADDR);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   logic r_err;
   assign w_ok    = imm_ok(kind_t'(bus.in_kind), bus.in_imm);
   assign bus.err = r_err;

   // A rejected beat is consumed but only leaves a one-cycle err pulse behind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_hs && !w_ok && !bus.flush;
      end
   end
`else
   assign w_ok    = 1'b1;
   assign bus.err = 1'b0;
`endif

   assign w_accept = w_hs && w_ok;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state; flush overrides everything
   always_comb begin
      w_next = r_state;
      if (bus.flush) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  w_next = w_accept ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_next = w_last ? ST_FULL : ST_IDLE;
            ST_FULL:  w_next = ST_FULL;
            default:  w_next = ST_IDLE;
         endcase
      end
   end

   // Datapath: word capture, write strobe, address counter and full flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= START_ADDR;
         r_word <= 32'h0000_0000;
         r_we   <= 1'b0;
         r_full <= 1'b0;
      end else if (bus.flush) begin
         r_cnt  <= START_ADDR;
         r_we   <= 1'b0;
         r_full <= 1'b0;
      end else begin
         r_we <= (r_state == ST_IDLE) && w_accept;
         if ((r_state == ST_IDLE) && w_accept) begin
            r_word <= w_word;
         end
         if (r_state == ST_WRITE) begin
            if (w_last) begin
               r_full <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   // A flush arriving during WRITE must kill the strobe in that same cycle
   assign bus.mem_we    = r_we && !bus.flush;
   assign bus.mem_addr  = r_cnt;
   assign bus.mem_wdata = r_word;
   assign bus.full      = r_full;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_WIDTH=2) with hand-computed expected words.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_addr;

   instr_encoder_if #(.ADDR_WIDTH(2)) bus ();

   instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic kind, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
      bus.in_kind   = kind;
      bus.in_funct3 = f3;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_imm    = imm;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
   endtask

   task automatic chk_write(input string tag, input int addr, input logic [31:0] word);
      chk({tag, "_we"},    32'(bus.mem_we),    32'd1);
      chk({tag, "_addr"},  32'(bus.mem_addr),  32'(addr));
      chk({tag, "_wdata"}, bus.mem_wdata,      word);
      chk({tag, "_rdy"},   32'(bus.in_ready),  32'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_kind   = 1'b0;
      bus.in_funct3 = 3'd0;
      bus.in_rd     = 5'd0;
      bus.in_rs1    = 5'd0;
      bus.in_rs2    = 5'd0;
      bus.in_imm    = 13'd0;
      bus.flush     = 1'b0;

      #2;
      chk("rst_we",    32'(bus.mem_we),   32'd0);
      chk("rst_addr",  32'(bus.mem_addr), 32'd0);
      chk("rst_wdata", bus.mem_wdata,     32'h0000_0000);
      chk("rst_full",  32'(bus.full),     32'd0);
      chk("rst_err",   32'(bus.err),      32'd0);
      chk("rst_rdy",   32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("idle_rdy", 32'(bus.in_ready), 32'd1);

      // addi x1, x0, 5
      send_beat(1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 13'd5);
      chk_write("itype", 0, 32'h0050_0093);
      tick();
      chk("itype_we_drop", 32'(bus.mem_we),   32'd0);
      chk("itype_next",    32'(bus.mem_addr), 32'd1);
      chk("itype_rdy",     32'(bus.in_ready), 32'd1);

      // bne x1, x0, -4
      send_beat(1'b1, 3'b001, 5'd0, 5'd1, 5'd0, 13'h1FFC);
      chk_write("btype", 1, 32'hFE00_9EE3);
      tick();
      exp_addr = 2;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      send_beat(1'b0, 3'b000, 5'd2, 5'd3, 5'd0, 13'h0800);
      chk("rng_i_err",  32'(bus.err),      32'd1);
      chk("rng_i_we",   32'(bus.mem_we),   32'd0);
      chk("rng_i_addr", 32'(bus.mem_addr), 32'd2);
      chk("rng_i_rdy",  32'(bus.in_ready), 32'd1);
      tick();
      chk("rng_i_err_drop", 32'(bus.err), 32'd0);
      send_beat(1'b1, 3'b000, 5'd0, 5'd1, 5'd2, 13'd3);
      chk("rng_b_err",  32'(bus.err),      32'd1);
      chk("rng_b_we",   32'(bus.mem_we),   32'd0);
      chk("rng_b_addr", 32'(bus.mem_addr), 32'd2);
      tick();
      chk("rng_b_err_drop", 32'(bus.err), 32'd0);
`else
      send_beat(1'b0, 3'b000, 5'd2, 5'd3, 5'd0, 13'h0800);
      chk_write("trunc", 2, 32'h8001_8113);
      chk("trunc_err", 32'(bus.err), 32'd0);
      tick();
      exp_addr = 3;
`endif

      // fill remaining addresses with addi xK, x0, 0
      while (exp_addr <= 3) begin
         send_beat(1'b0, 3'b000, 5'(exp_addr), 5'd0, 5'd0, 13'd0);
         chk_write("fill", exp_addr, 32'(exp_addr * 128 + 32'h13));
         chk("fill_full_pre", 32'(bus.full), 32'd0);
         tick();
         exp_addr++;
      end
      chk("full_set",  32'(bus.full),     32'd1);
      chk("full_addr", 32'(bus.mem_addr), 32'd3);
      chk("full_rdy",  32'(bus.in_ready), 32'd0);

      // fifth beat stalls
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_rdy",  32'(bus.in_ready), 32'd0);
         chk("stall_we",   32'(bus.mem_we),   32'd0);
         chk("stall_full", 32'(bus.full),     32'd1);
      end
      bus.in_valid = 1'b0;

      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      chk("flush_full", 32'(bus.full),     32'd0);
      chk("flush_addr", 32'(bus.mem_addr), 32'd0);
      chk("flush_rdy",  32'(bus.in_ready), 32'd1);

      // flush together with valid: beat refused
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      #1;
      chk("fv_rdy", 32'(bus.in_ready), 32'd0);
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("fv_we",   32'(bus.mem_we),   32'd0);
      chk("fv_addr", 32'(bus.mem_addr), 32'd0);
      tick();
      chk("fv_we2",  32'(bus.mem_we),   32'd0);

      send_beat(1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 13'd5);
      chk_write("reflush", 0, 32'h0050_0093);
      tick();
      chk("reflush_next", 32'(bus.mem_addr), 32'd1);

      // flush during WRITE suppresses strobe
      send_beat(1'b1, 3'b001, 5'd0, 5'd1, 5'd0, 13'h1FFC);
      bus.flush = 1'b1;
      #1;
      chk("fw_we", 32'(bus.mem_we), 32'd0);
      tick();
      bus.flush = 1'b0;
      #1;
      chk("fw_we2",  32'(bus.mem_we),   32'd0);
      chk("fw_addr", 32'(bus.mem_addr), 32'd0);
      chk("fw_rdy",  32'(bus.in_ready), 32'd1);

      // reset in the middle of WRITE
      send_beat(1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 13'd5);
      chk("rw_we_pre", 32'(bus.mem_we), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rw_we",    32'(bus.mem_we),   32'd0);
      chk("rw_addr",  32'(bus.mem_addr), 32'd0);
      chk("rw_wdata", bus.mem_wdata,     32'h0000_0000);
      chk("rw_full",  32'(bus.full),     32'd0);
      chk("rw_err",   32'(bus.err),      32'd0);
      chk("rw_rdy",   32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rw_idle_rdy", 32'(bus.in_ready), 32'd1);
      chk("rw_idle_we",  32'(bus.mem_we),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
